// File: rtl/program_loader.sv
// Assembles a big-endian byte stream into words and writes them to instruction memory.
// Latency: 4th byte -> write_enable next cycle -> start (on HALT_WORD) the cycle after.
// No backpressure: bytes arriving outside RECEIVE/WRITE are dropped, never stalled.
module program_loader #(
  parameter int                LENGTH     = 32,
  parameter int                BYTE_WIDTH = 8,
  parameter int                MEM_DEPTH  = 64,
  parameter logic [LENGTH-1:0] HALT_WORD  = {LENGTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_request,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [LENGTH-1:0]     instruction_to_write,
  output logic [LENGTH-1:0]     address_to_write,
  output logic                  write_enable,
  output logic                  start,
  output logic                  loading,
  output logic                  done,
  output logic                  overflow
);

  localparam int BYTES_PER_WORD = LENGTH / BYTE_WIDTH;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [LENGTH-1:0] LAST_ADDR = LENGTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  byte_cnt;
  logic [LENGTH-1:0] word_addr;
  logic [LENGTH-1:0] assembly;
  logic [LENGTH-1:0] next_word;
  logic              capture;

  assign next_word = {assembly[LENGTH-BYTE_WIDTH-1:0], rx_data};
  assign capture   = rx_valid && (state == RECEIVE || state == WRITE);
  assign loading   = (state == RECEIVE) || (state == WRITE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                <= IDLE;
      byte_cnt             <= '0;
      word_addr            <= '0;
      assembly             <= '0;
      instruction_to_write <= '0;
      address_to_write     <= '0;
      write_enable         <= 1'b0;
      start                <= 1'b0;
      overflow             <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      start        <= 1'b0;
      // A byte landing in the WRITE cycle already belongs to the next word.
      if (capture) begin
        assembly <= next_word;
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (load_request) begin
            state     <= RECEIVE;
            word_addr <= '0;
            byte_cnt  <= '0;
            assembly  <= '0;
            overflow  <= 1'b0;
          end
        end
        RECEIVE: begin
          if (!load_request) begin
            state <= IDLE;
          end else if (rx_valid && byte_cnt == LAST_BYTE) begin
            state                <= WRITE;
            write_enable         <= 1'b1;
            instruction_to_write <= next_word;
            address_to_write     <= word_addr;
          end
        end
        WRITE: begin
          if (!load_request) begin
            state <= IDLE;
          end else if (instruction_to_write == HALT_WORD) begin
            state <= DONE;
            start <= 1'b1;
          end else if (word_addr == LAST_ADDR) begin
            state    <= DONE;
            overflow <= 1'b1;
          end else begin
            word_addr <= word_addr + LENGTH'(1);
            state     <= RECEIVE;
          end
        end
        DONE: begin
          if (!load_request) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Drives two loaders (depth 64 and depth 4) from one byte stream and checks each
// against a word-list reference model computed from the received bytes.
module tb_program_loader;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [7:0] val;
    int         cyc;
  } rxb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_request = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic [31:0] ins_a, adr_a, ins_b, adr_b;
  logic        we_a, st_a, ld_a, dn_a, ov_a;
  logic        we_b, st_b, ld_b, dn_b, ov_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  rxb_t rx_q[$];
  wr_t  wr_qa[$];
  wr_t  wr_qb[$];
  int   st_qa[$];
  int   st_qb[$];

  program_loader dut_a (
    .clk(clk), .reset(reset), .load_request(load_request),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .instruction_to_write(ins_a), .address_to_write(adr_a),
    .write_enable(we_a), .start(st_a), .loading(ld_a), .done(dn_a), .overflow(ov_a)
  );

  program_loader #(.MEM_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .load_request(load_request),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .instruction_to_write(ins_b), .address_to_write(adr_b),
    .write_enable(we_b), .start(st_b), .loading(ld_b), .done(dn_b), .overflow(ov_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    wr_t w;
    rxb_t b;
    if (rx_valid) begin
      b.val = rx_data;
      b.cyc = cyc;
      rx_q.push_back(b);
    end
    if (we_a) begin
      w.addr = adr_a; w.data = ins_a; w.cyc = cyc;
      wr_qa.push_back(w);
    end
    if (we_b) begin
      w.addr = adr_b; w.data = ins_b; w.cyc = cyc;
      wr_qb.push_back(w);
    end
    if (st_a) st_qa.push_back(cyc);
    if (st_b) st_qb.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    rx_q.delete();
    wr_qa.delete();
    wr_qb.delete();
    st_qa.delete();
    st_qb.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    step(1);
    rx_valid = 1'b0;
    step(gap);
  endtask

  // gap < 0 picks a random 0..2 idle cycles after each byte
  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    end
  endtask

  task automatic new_session();
    load_request = 1'b0;
    step(2);
    load_request = 1'b1;
    step(1);
    clear_logs();
  endtask

  task automatic check_zero(input string p);
    check({p, " A ins"}, ins_a, 32'h0);
    check({p, " A adr"}, adr_a, 32'h0);
    check({p, " A flags"}, 32'({we_a, st_a, ld_a, dn_a, ov_a}), 32'h0);
    check({p, " B ins"}, ins_b, 32'h0);
    check({p, " B adr"}, adr_b, 32'h0);
    check({p, " B flags"}, 32'({we_b, st_b, ld_b, dn_b, ov_b}), 32'h0);
  endtask

  // Reference: every 4 received bytes form one word, written at consecutive
  // addresses until a HALT word or until depth words have been written.
  task automatic check_model(input string tag, input int which);
    wr_t  got[$];
    wr_t  exp[$];
    wr_t  e;
    int   st[$];
    int   depth, n, st_exp;
    bit   fin, halt;
    logic dn, ov, ld;
    logic [31:0] w;
    string p;
    if (which == 0) begin
      got = wr_qa; st = st_qa; dn = dn_a; ov = ov_a; ld = ld_a; depth = 64;
      p = {tag, " A"};
    end else begin
      got = wr_qb; st = st_qb; dn = dn_b; ov = ov_b; ld = ld_b; depth = 4;
      p = {tag, " B"};
    end
    fin = 1'b0; halt = 1'b0; st_exp = -1; n = 0;
    for (int i = 0; i + 3 < rx_q.size(); i += 4) begin
      if (!fin) begin
        w = {rx_q[i].val, rx_q[i+1].val, rx_q[i+2].val, rx_q[i+3].val};
        e.addr = 32'(n);
        e.data = w;
        e.cyc  = rx_q[i+3].cyc + 1;
        exp.push_back(e);
        n++;
        if (w == HALT) begin
          fin = 1'b1; halt = 1'b1; st_exp = rx_q[i+3].cyc + 2;
        end else if (n == depth) begin
          fin = 1'b1;
        end
      end
    end
    check({p, " write count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      check($sformatf("%s wr%0d addr", p, i), got[i].addr, exp[i].addr);
      check($sformatf("%s wr%0d data", p, i), got[i].data, exp[i].data);
      check($sformatf("%s wr%0d cycle", p, i), got[i].cyc, exp[i].cyc);
    end
    check({p, " start count"}, st.size(), halt ? 1 : 0);
    if (halt && st.size() > 0) check({p, " start cycle"}, st[0], st_exp);
    check({p, " done"}, 32'(dn), 32'(fin));
    check({p, " overflow"}, 32'(ov), 32'(fin && !halt));
    check({p, " loading"}, 32'(ld), 32'(!fin));
  endtask

  initial begin
    // Reset held with rx_valid toggling
    step(1);
    for (int i = 0; i < 3; i++) begin
      rx_valid = ~rx_valid;
      rx_data  = 8'hA5;
      step(1);
    end
    rx_valid = 1'b0;
    check_zero("reset");
    reset = 1'b1;
    step(1);

    // Basic three-word program ending in HALT
    new_session();
    send_word(32'h00000001, 1);
    send_word(32'h00000002, 1);
    send_word(HALT, 1);
    step(4);
    check_model("basic", 0);
    check_model("basic", 1);

    // Four non-halt words: depth-4 loader overflows without start
    new_session();
    send_word(32'h11111111, -1);
    send_word(32'h22222222, -1);
    send_word(32'h33333333, -1);
    send_word(32'h44444444, -1);
    step(4);
    check_model("ovf", 0);
    check_model("ovf", 1);
    check("ovf B overflow", 32'(ov_b), 32'h1);
    check("ovf B starts", st_qb.size(), 0);

    // Back-to-back bytes so one lands in the WRITE cycle
    new_session();
    send_word(32'hAABBCCDD, 0);
    send_word(32'h12345678, 0);
    send_word(HALT, 0);
    step(4);
    check_model("b2b", 0);
    check_model("b2b", 1);
    if (wr_qa.size() > 1) check("b2b second word", wr_qa[1].data, 32'h12345678);

    // Abort after two bytes, then re-arm
    new_session();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    load_request = 1'b0;
    step(3);
    check("abort A writes", wr_qa.size(), 0);
    check("abort B writes", wr_qb.size(), 0);
    check("abort A loading", 32'(ld_a), 32'h0);
    check("abort A done", 32'(dn_a), 32'h0);
    new_session();
    send_word(32'hCAFEF00D, -1);
    send_word(HALT, -1);
    step(4);
    check_model("rearm", 0);
    check_model("rearm", 1);
    if (wr_qa.size() > 0) check("rearm first addr", wr_qa[0].addr, 32'h0);

    // Reset mid-word after two writes
    new_session();
    send_word(32'h0BADBEEF, 0);
    send_word(32'h13579BDF, 0);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    check("midrst A writes", wr_qa.size(), 2);
    reset = 1'b0;
    step(2);
    check_zero("midrst");
    reset = 1'b1;
    step(1);
    clear_logs();
    send_word(32'h01020304, -1);
    send_word(HALT, -1);
    step(4);
    check_model("reload", 0);
    check_model("reload", 1);
    if (wr_qa.size() > 0) check("reload first addr", wr_qa[0].addr, 32'h0);

    // Random programs, with trailing bytes that a finished loader must ignore
    for (int s = 0; s < 12; s++) begin
      int nw;
      bit with_halt;
      nw = int'($urandom_range(1, 7));
      with_halt = ($urandom_range(0, 3) != 0);
      new_session();
      for (int k = 0; k < nw; k++) begin
        if (with_halt && k == nw - 1) send_word(HALT, -1);
        else send_word($urandom, -1);
      end
      for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
      step(4);
      check_model($sformatf("rand%0d", s), 0);
      check_model($sformatf("rand%0d", s), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
